rv32i_writeback: RTL and testbench
==================================

# rv32i_writeback

Writeback stage of the RV32I core, the return path of the ALU operand selector. The selector steers rs1/rs2/imm/pc into the ALU; this block takes the ALU result, load data or pc+4 under the same 3-bit select encoding and produces one register-file write. Loads are multi-cycle and complete on a memory read response. Byte/halfword loads are extended and aligned here, and retired instructions are counted.

## Interface
- TIMEOUT_CYCLES, 255: load-response watchdog limit in cycles; used only with WB_TIMEOUT_EN.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instruction presented for writeback.
- in_ready  output  1  block can accept; high only in IDLE.
- wb_sel  input  3  001 I-arith, 010 R-type, 011 pc-relative (ALU), 100 JAL, 101 JALR, 110 load; 000/111 no write.
- funct3  input  3  load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes are illegal.
- rd  input  5  destination register.
- alu_result  input  32  ALU output; for loads, the byte address.
- pc  input  32  instruction address.
- mem_rvalid  input  1  load data valid, one-cycle pulse.
- mem_rdata  input  32  aligned 32-bit word read from memory.
- rf_we  output  1  register-file write strobe, one cycle.
- rf_rd  output  5  write address.
- rf_wdata  output  32  write data.
- misalign  output  1  one-cycle pulse: misaligned load or illegal load funct3.
- load_fault  output  1  one-cycle pulse on watchdog expiry; constant 0 without WB_TIMEOUT_EN.
- retire_count  output  32  count of completed instructions.

## Operation
- States: IDLE, LOAD_WAIT.
- Accept means in_valid && in_ready in IDLE. The block latches rd, wb_sel, funct3, alu_result[1:0] and pc.
- wb_sel 001/010/011: data is alu_result. Write occurs the next cycle. State stays IDLE.
- wb_sel 100/101: data is pc+4 (32-bit, wraps mod 2^32). Write occurs the next cycle.
- wb_sel 000/111: no write. retire_count still increments.
- wb_sel 110 goes to LOAD_WAIT. In LOAD_WAIT, mem_rvalid writes the extracted data and returns to IDLE.
- Load extraction uses offset = alu_result[1:0]:
  - LB/LBU: byte mem_rdata[8*offset+7 : 8*offset], sign- or zero-extended.
  - LH/LHU: half-word at offset[1], sign- or zero-extended.
  - LW: the full word.
- Misaligned load means LH/LHU with offset[0]=1, LW with offset≠0, or an illegal funct3. The block pulses misalign, makes no write, stays IDLE and does not retire the instruction.
- rd=0 suppresses rf_we. The instruction still retires. rf_rd and rf_wdata are still driven.
- mem_rvalid is ignored in IDLE, including the acceptance cycle.
- retire_count increments on every completed write or no-write instruction. It wraps from 0xFFFF_FFFF to 0.
- Reset at any time returns to IDLE and discards a pending load. A mem_rvalid arriving after reset is ignored.

## Timing
- Reset values: state IDLE, in_ready 1, rf_we 0, rf_rd 0, rf_wdata 0, misalign 0, load_fault 0, retire_count 0, watchdog 0.
- All outputs are registered except in_ready, which is decoded from state.
- Non-load accepted in cycle N: rf_we high in N+1. in_ready stays high, so back-to-back accepts give one write per cycle.
- Load accepted in cycle N: in_ready low from N+1. mem_rvalid sampled in cycle M (M ≥ N+1) gives rf_we high and in_ready high in M+1.
- Minimum load latency is 2 cycles.
- misalign pulses in N+1.
- rf_rd and rf_wdata hold their last value while rf_we is low.

## Configuration
- WB_TIMEOUT_EN defined:
  - A watchdog clears on load accept and counts each cycle in LOAD_WAIT without mem_rvalid.
  - When the count reaches TIMEOUT_CYCLES, load_fault pulses for one cycle and the state returns to IDLE with no write and no retire.
  - If mem_rvalid arrives in the expiry cycle, it wins and a normal write occurs.
- WB_TIMEOUT_EN undefined: LOAD_WAIT waits indefinitely, there is no watchdog logic, and load_fault is tied to 0.

## Test plan
- Reset mid-load: accept LW, assert rst before mem_rvalid, then pulse mem_rvalid → no rf_we, retire_count=0, in_ready=1.
- Back-to-back ALU ops: accept wb_sel=010 rd=5 alu=0x1234 then wb_sel=001 rd=6 alu=0xFFFF_FFFF on consecutive cycles → rf_we in two consecutive cycles with (5,0x1234) then (6,0xFFFF_FFFF); retire_count=2.
- JAL with pc=0xFFFF_FFFC, rd=1 → rf_wdata=0x0000_0000. rd=0 variant → rf_we stays 0 and retire_count still increments.
- Load extraction with mem_rdata=0x80FF_7F01:
  - LB at offset 3 → 0xFFFF_FF80.
  - LBU at offset 1 → 0x0000_007F.
  - LH at offset 2 → 0xFFFF_80FF.
  - LW at offset 0 → 0x80FF_7F01.
  - Each write lands one cycle after mem_rvalid.
- Misaligned loads: LW at offset 2 and LHU at offset 1 → misalign pulse, no write, in_ready stays 1, retire_count unchanged.
- With WB_TIMEOUT_EN and TIMEOUT_CYCLES=4, accept a load with no mem_rvalid → load_fault pulse, return to IDLE, no write. Repeat with mem_rvalid in the expiry cycle → normal write and no load_fault.

Source files
------------

// File: rtl/rv32i_writeback_if.sv
// +--------------------------------------------------------------------------+
// | rv32i_writeback_if                                                       |
// | Bundle of the writeback stage's instruction handshake, memory read       |
// | response and register-file write signals.                                |
// |   master : instruction source / memory side (drives in_*, mem_*)         |
// |   slave  : writeback stage (drives in_ready, rf_*, misalign, load_fault,  |
// |            retire_count)                                                 |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

interface rv32i_writeback_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  wb_sel;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        misalign;
  logic        load_fault;
  logic [31:0] retire_count;

  modport master (
    output in_valid, wb_sel, funct3, rd, alu_result, pc, mem_rvalid, mem_rdata,
    input  in_ready, rf_we, rf_rd, rf_wdata, misalign, load_fault, retire_count
  );

  modport slave (
    input  in_valid, wb_sel, funct3, rd, alu_result, pc, mem_rvalid, mem_rdata,
    output in_ready, rf_we, rf_rd, rf_wdata, misalign, load_fault, retire_count
  );
endinterface

`default_nettype wire

// File: rtl/rv32i_writeback.sv
// +--------------------------------------------------------------------------+
// | rv32i_writeback                                                          |
// | RV32I writeback stage: selects ALU result, pc+4 or extracted load data   |
// | and issues one register-file write per instruction; counts retirements. |
// | Ports:                                                                   |
// |   clk, rst  : clock, asynchronous active-high reset                      |
// |   bus       : rv32i_writeback_if.slave (instruction in, memory response, |
// |               register-file write, misalign/load_fault, retire_count)    |
// | Parameters: TIMEOUT_CYCLES - load-response watchdog limit                |
// | Optional feature macro: WB_TIMEOUT_EN enables the load watchdog.         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module rv32i_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  rv32i_writeback_if.slave bus
);

  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_LOAD_WAIT = 1'b1;

  localparam logic [2:0] SEL_IARITH = 3'b001;
  localparam logic [2:0] SEL_RTYPE  = 3'b010;
  localparam logic [2:0] SEL_PCREL  = 3'b011;
  localparam logic [2:0] SEL_JAL    = 3'b100;
  localparam logic [2:0] SEL_JALR   = 3'b101;
  localparam logic [2:0] SEL_LOAD   = 3'b110;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [0:0]  state_q, state_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        misalign_q, misalign_d;
  logic [31:0] retire_q, retire_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        accept;
  logic        load_bad;
  logic        wd_expire;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  assign accept       = bus.in_valid && (state_q == ST_IDLE);
  assign bus.in_ready = (state_q == ST_IDLE);

  // Alignment / legality of a load, judged on the presented instruction.
  always_comb begin
    load_bad = 1'b0;
    case (bus.funct3)
      F3_LB, F3_LBU: load_bad = 1'b0;
      F3_LH, F3_LHU: load_bad = bus.alu_result[0];
      F3_LW:         load_bad = |bus.alu_result[1:0];
      default:       load_bad = 1'b1;
    endcase
  end

  // Extraction uses the captured width/offset; only legal codes reach here.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = bus.mem_rdata[7:0];
      2'd1:    byte_sel = bus.mem_rdata[15:8];
      2'd2:    byte_sel = bus.mem_rdata[23:16];
      default: byte_sel = bus.mem_rdata[31:24];
    endcase
    half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'h000000, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = bus.mem_rdata;
    endcase
  end

`ifdef WB_TIMEOUT_EN
  // Counter runs 0 .. TIMEOUT_CYCLES-1 across the wait cycles; the cycle in
  // which it sits at the last value without a response is the expiry cycle.
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            load_fault_q;

  assign wd_expire = (state_q == ST_LOAD_WAIT) && !bus.mem_rvalid && (wd_q == WD_LAST);

  always_comb begin
    wd_d = wd_q;
    if (state_q == ST_IDLE) begin
      wd_d = '0;
    end else if (!bus.mem_rvalid) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q         <= '0;
      load_fault_q <= 1'b0;
    end else begin
      wd_q         <= wd_d;
      load_fault_q <= wd_expire;
    end
  end

  assign bus.load_fault = load_fault_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT_CYCLES;
  assign wd_expire      = 1'b0;
  assign bus.load_fault = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
      misalign_q <= 1'b0;
      retire_q   <= 32'd0;
      rd_q       <= 5'd0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      misalign_q <= misalign_d;
      retire_q   <= retire_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (bus.wb_sel == SEL_LOAD) && !load_bad) begin
          state_d = ST_LOAD_WAIT;
        end
      end
      default: begin
        if (bus.mem_rvalid || wd_expire) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // Output / datapath logic. rd=0 still updates rf_rd/rf_wdata but not rf_we.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    misalign_d = 1'b0;
    retire_d   = retire_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (bus.wb_sel)
            SEL_IARITH, SEL_RTYPE, SEL_PCREL: begin
              rf_we_d    = |bus.rd;
              rf_rd_d    = bus.rd;
              rf_wdata_d = bus.alu_result;
              retire_d   = retire_q + 32'd1;
            end
            SEL_JAL, SEL_JALR: begin
              rf_we_d    = |bus.rd;
              rf_rd_d    = bus.rd;
              rf_wdata_d = bus.pc + 32'd4;
              retire_d   = retire_q + 32'd1;
            end
            SEL_LOAD: begin
              if (load_bad) begin
                misalign_d = 1'b1;
              end else begin
                rd_d     = bus.rd;
                funct3_d = bus.funct3;
                off_d    = bus.alu_result[1:0];
              end
            end
            default: retire_d = retire_q + 32'd1;
          endcase
        end
      end
      default: begin
        if (bus.mem_rvalid) begin
          rf_we_d    = |rd_q;
          rf_rd_d    = rd_q;
          rf_wdata_d = load_data;
          retire_d   = retire_q + 32'd1;
        end
      end
    endcase
  end

  assign bus.rf_we        = rf_we_q;
  assign bus.rf_rd        = rf_rd_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.misalign     = misalign_q;
  assign bus.retire_count = retire_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_writeback.sv
// +--------------------------------------------------------------------------+
// | tb_rv32i_writeback                                                       |
// | Directed self-checking bench for rv32i_writeback.                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rv32i_writeback;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] exp_retire;

  always #5 clk = ~clk;

  rv32i_writeback_if bus();

  rv32i_writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] pc);
    bus.in_valid   = v;
    bus.wb_sel     = sel;
    bus.funct3     = f3;
    bus.rd         = rd;
    bus.alu_result = alu;
    bus.pc         = pc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 3'b000, 3'b000, 5'd0, 32'd0, 32'd0);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
    tick();
    tick();
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b expected 0", bus.rf_we); end
    n_checks++; if (bus.rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rf_rd: got %0d expected 0", bus.rf_rd); end
    n_checks++; if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata: got %h expected 0", bus.rf_wdata); end
    n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", bus.misalign); end
    n_checks++; if (bus.load_fault !== 1'b0) begin n_fail++; $display("FAIL reset_load_fault: got %b expected 0", bus.load_fault); end
    n_checks++; if (bus.retire_count !== 32'd0) begin n_fail++; $display("FAIL reset_retire: got %h expected 0", bus.retire_count); end
    rst = 1'b0;
    exp_retire = 32'd0;
    tick();
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 3'b010, 3'b000, 5'd5, 32'h0000_1234, 32'h0000_0100);
    tick();
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we0: got %b expected 1", bus.rf_we); end
    n_checks++; if (bus.rf_rd !== 5'd5) begin n_fail++; $display("FAIL b2b_rd0: got %0d expected 5", bus.rf_rd); end
    n_checks++; if (bus.rf_wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL b2b_data0: got %h expected 00001234", bus.rf_wdata); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", bus.in_ready); end
    drive(1'b1, 3'b001, 3'b000, 5'd6, 32'hFFFF_FFFF, 32'h0000_0104);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL b2b_we1: got %b expected 1", bus.rf_we); end
    n_checks++; if (bus.rf_rd !== 5'd6) begin n_fail++; $display("FAIL b2b_rd1: got %0d expected 6", bus.rf_rd); end
    n_checks++; if (bus.rf_wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_data1: got %h expected ffffffff", bus.rf_wdata); end
    tick();
    exp_retire = 32'd2;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL b2b_we_idle: got %b expected 0", bus.rf_we); end
    n_checks++; if (bus.rf_wdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL b2b_data_hold: got %h expected ffffffff", bus.rf_wdata); end
    n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL b2b_retire: got %0d expected %0d", bus.retire_count, exp_retire); end
  endtask

  task automatic test_jal;
    drive(1'b1, 3'b100, 3'b000, 5'd1, 32'h0000_AAAA, 32'hFFFF_FFFC);
    tick();
    bus.in_valid = 1'b0;
    exp_retire = exp_retire + 32'd1;
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL jal_we: got %b expected 1", bus.rf_we); end
    n_checks++; if (bus.rf_rd !== 5'd1) begin n_fail++; $display("FAIL jal_rd: got %0d expected 1", bus.rf_rd); end
    n_checks++; if (bus.rf_wdata !== 32'h0000_0000) begin n_fail++; $display("FAIL jal_wrap: got %h expected 00000000", bus.rf_wdata); end
    n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL jal_retire: got %0d expected %0d", bus.retire_count, exp_retire); end
    drive(1'b1, 3'b101, 3'b000, 5'd0, 32'h0000_5555, 32'h0000_0010);
    tick();
    bus.in_valid = 1'b0;
    exp_retire = exp_retire + 32'd1;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL jalr_rd0_we: got %b expected 0", bus.rf_we); end
    n_checks++; if (bus.rf_wdata !== 32'h0000_0014) begin n_fail++; $display("FAIL jalr_rd0_data: got %h expected 00000014", bus.rf_wdata); end
    n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL jalr_rd0_retire: got %0d expected %0d", bus.retire_count, exp_retire); end
    drive(1'b1, 3'b000, 3'b000, 5'd7, 32'h0000_7777, 32'h0000_0020);
    tick();
    drive(1'b1, 3'b111, 3'b000, 5'd9, 32'h0000_9999, 32'h0000_0024);
    tick();
    bus.in_valid = 1'b0;
    exp_retire = exp_retire + 32'd2;
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL nowrite_we: got %b expected 0", bus.rf_we); end
    n_checks++; if (bus.rf_rd !== 5'd0) begin n_fail++; $display("FAIL nowrite_rd_hold: got %0d expected 0", bus.rf_rd); end
    n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL nowrite_retire: got %0d expected %0d", bus.retire_count, exp_retire); end
  endtask

  task automatic test_load_extract;
    logic [2:0]  f3_tab  [0:7];
    logic [1:0]  off_tab [0:7];
    logic [31:0] exp_tab [0:7];
    f3_tab[0] = 3'b000; off_tab[0] = 2'd3; exp_tab[0] = 32'hFFFF_FF80;
    f3_tab[1] = 3'b100; off_tab[1] = 2'd1; exp_tab[1] = 32'h0000_007F;
    f3_tab[2] = 3'b001; off_tab[2] = 2'd2; exp_tab[2] = 32'hFFFF_80FF;
    f3_tab[3] = 3'b010; off_tab[3] = 2'd0; exp_tab[3] = 32'h80FF_7F01;
    f3_tab[4] = 3'b101; off_tab[4] = 2'd2; exp_tab[4] = 32'h0000_80FF;
    f3_tab[5] = 3'b000; off_tab[5] = 2'd0; exp_tab[5] = 32'h0000_0001;
    f3_tab[6] = 3'b100; off_tab[6] = 2'd3; exp_tab[6] = 32'h0000_0080;
    f3_tab[7] = 3'b001; off_tab[7] = 2'd0; exp_tab[7] = 32'h0000_7F01;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'b110, f3_tab[i], 5'(i + 8), 32'h0000_1000 | {30'd0, off_tab[i]}, 32'h0000_0200);
      // First entry also pulses a stray response in the accept cycle.
      bus.mem_rvalid = (i == 0);
      bus.mem_rdata  = (i == 0) ? 32'hDEAD_BEEF : 32'h80FF_7F01;
      tick();
      bus.in_valid   = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'h80FF_7F01;
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL load%0d_busy: got %b expected 0", i, bus.in_ready); end
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL load%0d_early_we: got %b expected 0", i, bus.rf_we); end
      bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      exp_retire = exp_retire + 32'd1;
      n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL load%0d_we: got %b expected 1", i, bus.rf_we); end
      n_checks++; if (bus.rf_rd !== 5'(i + 8)) begin n_fail++; $display("FAIL load%0d_rd: got %0d expected %0d", i, bus.rf_rd, i + 8); end
      n_checks++; if (bus.rf_wdata !== exp_tab[i]) begin n_fail++; $display("FAIL load%0d_data: got %h expected %h", i, bus.rf_wdata, exp_tab[i]); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL load%0d_ready: got %b expected 1", i, bus.in_ready); end
      n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL load%0d_retire: got %0d expected %0d", i, bus.retire_count, exp_retire); end
      tick();
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL load%0d_we_pulse: got %b expected 0", i, bus.rf_we); end
    end
  endtask

  task automatic test_misalign;
    logic [2:0] f3_tab  [0:3];
    logic [1:0] off_tab [0:3];
    f3_tab[0] = 3'b010; off_tab[0] = 2'd2;
    f3_tab[1] = 3'b101; off_tab[1] = 2'd1;
    f3_tab[2] = 3'b011; off_tab[2] = 2'd0;
    f3_tab[3] = 3'b001; off_tab[3] = 2'd3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b110, f3_tab[i], 5'd12, 32'h0000_3000 | {30'd0, off_tab[i]}, 32'h0000_0300);
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.misalign !== 1'b1) begin n_fail++; $display("FAIL mis%0d_pulse: got %b expected 1", i, bus.misalign); end
      n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL mis%0d_we: got %b expected 0", i, bus.rf_we); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mis%0d_ready: got %b expected 1", i, bus.in_ready); end
      n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL mis%0d_retire: got %0d expected %0d", i, bus.retire_count, exp_retire); end
      tick();
      n_checks++; if (bus.misalign !== 1'b0) begin n_fail++; $display("FAIL mis%0d_clear: got %b expected 0", i, bus.misalign); end
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout;
    drive(1'b1, 3'b110, 3'b010, 5'd14, 32'h0000_4000, 32'h0000_0400);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (bus.load_fault !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL to_wait%0d: fault %b ready %b expected 0 0", k, bus.load_fault, bus.in_ready); end
    end
    tick();
    n_checks++; if (bus.load_fault !== 1'b1) begin n_fail++; $display("FAIL to_fault: got %b expected 1", bus.load_fault); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL to_we: got %b expected 0", bus.rf_we); end
    n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL to_retire: got %0d expected %0d", bus.retire_count, exp_retire); end
    tick();
    n_checks++; if (bus.load_fault !== 1'b0) begin n_fail++; $display("FAIL to_fault_pulse: got %b expected 0", bus.load_fault); end
    drive(1'b1, 3'b110, 3'b010, 5'd15, 32'h0000_4000, 32'h0000_0404);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1357_9BDF;
    tick();
    bus.mem_rvalid = 1'b0;
    exp_retire = exp_retire + 32'd1;
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL to_race_we: got %b expected 1", bus.rf_we); end
    n_checks++; if (bus.rf_wdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL to_race_data: got %h expected 13579bdf", bus.rf_wdata); end
    n_checks++; if (bus.load_fault !== 1'b0) begin n_fail++; $display("FAIL to_race_fault: got %b expected 0", bus.load_fault); end
    n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL to_race_retire: got %0d expected %0d", bus.retire_count, exp_retire); end
  endtask
`else
  task automatic test_no_timeout;
    int bad;
    bad = 0;
    drive(1'b1, 3'b110, 3'b010, 5'd14, 32'h0000_4000, 32'h0000_0400);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (bus.load_fault !== 1'b0 || bus.in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL nowd_wait: got %0d bad cycles expected 0", bad); end
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h2468_ACE0;
    tick();
    bus.mem_rvalid = 1'b0;
    exp_retire = exp_retire + 32'd1;
    n_checks++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL nowd_we: got %b expected 1", bus.rf_we); end
    n_checks++; if (bus.rf_wdata !== 32'h2468_ACE0) begin n_fail++; $display("FAIL nowd_data: got %h expected 2468ace0", bus.rf_wdata); end
    n_checks++; if (bus.retire_count !== exp_retire) begin n_fail++; $display("FAIL nowd_retire: got %0d expected %0d", bus.retire_count, exp_retire); end
  endtask
`endif

  task automatic test_reset_mid_load;
    drive(1'b1, 3'b110, 3'b010, 5'd20, 32'h0000_5000, 32'h0000_0500);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rml_busy: got %b expected 0", bus.in_ready); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rml_async_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.retire_count !== 32'd0) begin n_fail++; $display("FAIL rml_async_retire: got %0d expected 0", bus.retire_count); end
    tick();
    rst = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE_F00D;
    tick();
    bus.mem_rvalid = 1'b0;
    tick();
    n_checks++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rml_we: got %b expected 0", bus.rf_we); end
    n_checks++; if (bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL rml_data: got %h expected 0", bus.rf_wdata); end
    n_checks++; if (bus.retire_count !== 32'd0) begin n_fail++; $display("FAIL rml_retire: got %0d expected 0", bus.retire_count); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rml_ready: got %b expected 1", bus.in_ready); end
    exp_retire = 32'd0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_jal();
    test_load_extract();
    test_misalign();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
